// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus shift-add multiply and
// restoring divide, one bit per cycle. Outputs are registered and only
// change on the Done pulse.
module alu_multicycle #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       ALUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Ready,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] ResultHi,
    output logic             Zero,
    output logic             Overflow,
    output logic             CarryOut
);
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DIV} state_t;
    typedef enum logic [2:0] {
        OP_AND  = 3'b000, OP_OR  = 3'b001, OP_ADD = 3'b010, OP_MULU = 3'b011,
        OP_DIVU = 3'b100, OP_NOR = 3'b101, OP_SUB = 3'b110, OP_SLT  = 3'b111
    } op_t;

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [WIDTH-1:0] lo_q, lo_d;    // operand A; multiplier / dividend->quotient while iterating
    logic [WIDTH-1:0] opb_q, opb_d;  // operand B; multiplicand / divisor
    logic [WIDTH-1:0] hi_q, hi_d;    // partial product high half / partial remainder
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] res_q, res_d, reshi_q, reshi_d;
    logic             zero_q, zero_d, ovf_q, ovf_d, cy_q, cy_d;

    // Shared adder for ADD/SUB/SLT: A + B or A + ~B + 1
    logic             sub_sel;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH:0]   sum;
    logic             c_in_msb;
    assign sub_sel  = (op_q == OP_SUB) || (op_q == OP_SLT);
    assign add_b    = sub_sel ? ~opb_q : opb_q;
    assign sum      = {1'b0, lo_q} + {1'b0, add_b} + {{WIDTH{1'b0}}, sub_sel};
    assign c_in_msb = sum[WIDTH-1] ^ lo_q[WIDTH-1] ^ add_b[WIDTH-1];

    // Shift-add step: conditionally add multiplicand to high half, then shift {carry,hi,lo} right
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi, mul_lo;
    assign mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opb_q : {WIDTH{1'b0}})};
    assign mul_hi  = mul_sum[WIDTH:1];
    assign mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};

    // Restoring-divide step; a zero divisor always "subtracts", which leaves
    // quotient all ones and shifts the dividend into the remainder unchanged
    logic [WIDTH:0]   div_shift, div_trial;
    logic             div_by_zero, div_ge;
    logic [WIDTH-1:0] div_hi, div_lo;
    assign div_shift   = {hi_q, lo_q[WIDTH-1]};
    assign div_trial   = div_shift - {1'b0, opb_q};
    assign div_by_zero = (opb_q == '0);
    assign div_ge      = div_by_zero || !div_trial[WIDTH];
    assign div_hi      = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_lo      = {lo_q[WIDTH-2:0], div_ge};

    // Single-cycle result evaluated from the registered operands during EXEC
    logic [WIDTH-1:0] alu_res;
    logic             alu_cy, alu_ovf;
    always_comb begin
        alu_res = '0;
        alu_cy  = 1'b0;
        alu_ovf = 1'b0;
        case (op_q)
            OP_AND: alu_res = lo_q & opb_q;
            OP_OR:  alu_res = lo_q | opb_q;
            OP_NOR: alu_res = ~(lo_q | opb_q);
            OP_ADD, OP_SUB: begin
                alu_res = sum[WIDTH-1:0];
                alu_cy  = sum[WIDTH];
                alu_ovf = c_in_msb ^ sum[WIDTH];
            end
            OP_SLT: begin
                alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ (c_in_msb ^ sum[WIDTH])};
                alu_cy  = sum[WIDTH];
            end
            default: ;
        endcase
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        lo_d    = lo_q;
        opb_d   = opb_q;
        hi_d    = hi_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        res_d   = res_q;
        reshi_d = reshi_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        cy_d    = cy_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    op_d  = op_t'(ALUOp);
                    lo_d  = A;
                    opb_d = B;
                    hi_d  = '0;
                    cnt_d = CW'(WIDTH - 1);
                    case (op_t'(ALUOp))
                        OP_MULU: state_d = S_MUL;
                        OP_DIVU: state_d = S_DIV;
                        default: state_d = S_EXEC;
                    endcase
                end
            end
            S_EXEC: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                res_d   = alu_res;
                reshi_d = '0;
                zero_d  = (alu_res == '0);
                ovf_d   = alu_ovf;
                cy_d    = alu_cy;
            end
            S_MUL: begin
                hi_d  = mul_hi;
                lo_d  = mul_lo;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    res_d   = mul_lo;
                    reshi_d = mul_hi;
                    zero_d  = (mul_lo == '0);
                    ovf_d   = 1'b0;
                    cy_d    = 1'b0;
                end
            end
            S_DIV: begin
                hi_d  = div_hi;
                lo_d  = div_lo;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    res_d   = div_lo;
                    reshi_d = div_hi;
                    zero_d  = (div_lo == '0);
                    ovf_d   = div_by_zero;
                    cy_d    = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_AND;
            lo_q    <= '0;
            opb_q   <= '0;
            hi_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            res_q   <= '0;
            reshi_q <= '0;
            zero_q  <= 1'b1;
            ovf_q   <= 1'b0;
            cy_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            lo_q    <= lo_d;
            opb_q   <= opb_d;
            hi_q    <= hi_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            res_q   <= res_d;
            reshi_q <= reshi_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            cy_q    <= cy_d;
        end
    end

    assign Ready    = (state_q == S_IDLE);
    assign Done     = done_q;
    assign Result   = res_q;
    assign ResultHi = reshi_q;
    assign Zero     = zero_q;
    assign Overflow = ovf_q;
    assign CarryOut = cy_q;
endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL provide parameter: WIDTH, 16, operand/result width in bits (legal range 4..64).
REQ-002 SHALL provide port: Clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port: Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port: Start  input  1  request; sampled only when Ready=1.
REQ-005 SHALL provide port: ALUOp  input  3  operation select, sampled with Start.
REQ-006 SHALL provide port: A  input  WIDTH  operand A, sampled with Start.
REQ-007 SHALL provide port: B  input  WIDTH  operand B, sampled with Start.
REQ-008 SHALL provide port: Ready  output  1  high in IDLE; block accepts Start.
REQ-009 SHALL provide port: Done  output  1  one-cycle pulse marking valid results.
REQ-010 SHALL provide port: Result  output  WIDTH  low result / quotient.
REQ-011 SHALL provide port: ResultHi  output  WIDTH  product high half / remainder; zero for other ops.
REQ-012 SHALL provide port: Zero  output  1  Result == 0.
REQ-013 SHALL provide port: Overflow  output  1  signed overflow (ADD/SUB), divide-by-zero (DIVU), else 0.
REQ-014 SHALL provide port: CarryOut  output  1  carry out of MSB (ADD/SUB/SLT), else 0.

Function
REQ-015 SHALL decode ALUOp: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 011 MULU, 100 DIVU, 101 NOR.
REQ-016 SHALL implement states IDLE, EXEC, MUL, DIV; IDLE->EXEC on Start with single-cycle op, IDLE->MUL on MULU, IDLE->DIV on DIVU.
REQ-017 SHALL register A, B, ALUOp on the accepting edge; later input changes SHALL NOT affect the operation.
REQ-018 SHALL ignore Start while Ready=0 (no queueing, no error).
REQ-019 Single-cycle ops: EXEC lasts one cycle, results and Done=1 in the cycle after EXEC (Start to Done latency 2 cycles), then IDLE.
REQ-020 SUB/SLT SHALL compute A + ~B + 1; CarryOut = MSB carry; Overflow = carry into MSB XOR carry out of MSB (SUB/ADD only).
REQ-021 SLT SHALL set Result = {WIDTH-1 zeros, sign(A-B) XOR overflow(A-B)} (correct signed compare), Overflow=0.
REQ-022 MULU SHALL use shift-add, one bit per cycle, exactly WIDTH cycles in MUL; {ResultHi,Result} = A*B unsigned, full 2*WIDTH bits; Start to Done latency WIDTH+1.
REQ-023 DIVU SHALL use restoring division, one bit per cycle, exactly WIDTH cycles in DIV; Result = A/B, ResultHi = A%B unsigned; latency WIDTH+1.
REQ-024 DIVU with B=0 SHALL give Result = all ones, ResultHi = A, Overflow=1, same latency.
REQ-025 Result, ResultHi, Zero, Overflow, CarryOut SHALL hold their values from Done until the next Done; SHALL NOT show intermediate iteration values.
REQ-026 Ready SHALL return to 1 in the same cycle Done=1; Start in that cycle SHALL be accepted (back-to-back).
REQ-027 Unused ALUOp encodings: none; all 8 codes defined.

Reset
REQ-028 Reset=1 at a clock edge SHALL force IDLE, Ready=1, Done=0, Result=0, ResultHi=0, Zero=1, Overflow=0, CarryOut=0.
REQ-029 Reset SHALL take priority over Start in the same cycle; operation in progress SHALL be aborted with no Done.

Verification
REQ-030 WIDTH=16, ADD A=0x7FFF B=0x0001 -> Done 2 cycles after Start, Result=0x8000, Overflow=1, CarryOut=0, Zero=0.
REQ-031 WIDTH=16, SUB A=0x0005 B=0x0005 -> Result=0x0000, Zero=1, CarryOut=1, Overflow=0; SLT A=0xFFFF B=0x0001 -> Result=0x0001.
REQ-032 WIDTH=16, MULU A=0xFFFF B=0xFFFF -> Done at cycle 17 after Start, ResultHi=0xFFFE, Result=0x0001; Ready=0 cycles 1..16, Start pulses there ignored.
REQ-033 WIDTH=16, DIVU A=0x0064 B=0x0007 -> Result=0x000E, ResultHi=0x0002; DIVU B=0 A=0x1234 -> Result=0xFFFF, ResultHi=0x1234, Overflow=1.
REQ-034 Reset asserted at cycle 5 of a MULU -> next cycle Ready=1, Result=0, no Done pulse; new ADD then completes normally.
REQ-035 WIDTH=8 and WIDTH=32 regression: random ops vs reference model, plus back-to-back Start on Done cycle -> every op accepted, results match.
